// File: rtl/hwpe_subsystem_ctrl.sv
// Control shell between an HWPE's flat TCDM master ports and the cluster
// crossbar: per-port outstanding throttling, busy derivation, drained
// completion/error events, a small register slave and an auto clock gate.
//
// state  | meaning
// ACTIVE | accelerator clock running, waiting for a quiet cycle
// IDLE   | quiet, counting idle cycles towards gating
// GATED  | accelerator clock disabled until a wake event
module hwpe_subsystem_ctrl #(
  parameter int N_CORES         = 8,
  parameter int N_MASTER_PORT   = 4,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int IDLE_CYCLES     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          test_mode,
  input  logic [N_MASTER_PORT-1:0]      acc_req_i,
  input  logic [N_MASTER_PORT-1:0]      acc_wen_i,
  input  logic [N_MASTER_PORT*32-1:0]   acc_add_i,
  input  logic [N_MASTER_PORT*32-1:0]   acc_wdata_i,
  input  logic [N_MASTER_PORT*4-1:0]    acc_be_i,
  output logic [N_MASTER_PORT-1:0]      acc_gnt_o,
  output logic [N_MASTER_PORT-1:0]      acc_r_valid_o,
  output logic [N_MASTER_PORT*32-1:0]   acc_r_rdata_o,
  output logic [N_MASTER_PORT-1:0]      tcdm_req_o,
  output logic [N_MASTER_PORT-1:0]      tcdm_wen_o,
  output logic [N_MASTER_PORT*32-1:0]   tcdm_add_o,
  output logic [N_MASTER_PORT*32-1:0]   tcdm_wdata_o,
  output logic [N_MASTER_PORT*4-1:0]    tcdm_be_o,
  input  logic [N_MASTER_PORT-1:0]      tcdm_gnt_i,
  input  logic [N_MASTER_PORT-1:0]      tcdm_r_valid_i,
  input  logic [N_MASTER_PORT*32-1:0]   tcdm_r_rdata_i,
  input  logic                          cfg_req_i,
  input  logic                          cfg_wen_i,
  input  logic [31:0]                   cfg_add_i,
  input  logic [31:0]                   cfg_wdata_i,
  input  logic [3:0]                    cfg_be_i,
  input  logic [ID_WIDTH-1:0]           cfg_id_i,
  output logic                          cfg_gnt_o,
  output logic                          cfg_r_valid_o,
  output logic [31:0]                   cfg_r_rdata_o,
  output logic [ID_WIDTH-1:0]           cfg_r_id_o,
  input  logic                          acc_busy_i,
  input  logic                          acc_done_i,
  output logic [N_CORES*2-1:0]          evt_o,
  output logic                          busy_o,
  output logic                          clk_en_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int IW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

  typedef enum logic [1:0] {ACTIVE, IDLE, GATED} state_t;

  logic [CW-1:0]            cnt [N_MASTER_PORT];
  logic [N_MASTER_PORT-1:0] stall, inc, perr, nz;
  logic                     all_idle, done_fire, done_pend, err, err_clr, autogate;
  logic [N_CORES-1:0]       evt_mask, mask_n;
  logic [31:0]              rd_data;
  logic                     cfg_wr, cfg_rd;
  logic [1:0]               sel;
  state_t                   state, state_n;
  logic [IW-1:0]            idle_cnt, idle_cnt_n;
  logic                     unused_bits;

  assign unused_bits = ^{cfg_add_i, cfg_wdata_i, cfg_be_i};

  // Per-port stall, accepted-request and protocol-error decode
  always_comb begin
    for (int p = 0; p < N_MASTER_PORT; p++) begin
      stall[p] = (cnt[p] == CW'(MAX_OUTSTANDING));
      nz[p]    = (cnt[p] != '0);
      inc[p]   = acc_req_i[p] & ~stall[p] & tcdm_gnt_i[p];
      perr[p]  = tcdm_r_valid_i[p] & ~nz[p] & ~inc[p];
    end
  end

  assign tcdm_req_o    = acc_req_i & ~stall;
  assign acc_gnt_o     = tcdm_gnt_i & ~stall;
  assign tcdm_wen_o    = acc_wen_i;
  assign tcdm_add_o    = acc_add_i;
  assign tcdm_wdata_o  = acc_wdata_i;
  assign tcdm_be_o     = acc_be_i;
  assign acc_r_valid_o = tcdm_r_valid_i;
  assign acc_r_rdata_o = tcdm_r_rdata_i;

  assign all_idle  = ~|nz;
  assign done_fire = done_pend & all_idle;

  // Outstanding counters; a stray response on an empty port leaves it at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_MASTER_PORT; p++) cnt[p] <= '0;
    end else begin
      for (int p = 0; p < N_MASTER_PORT; p++) begin
        if (inc[p] && !tcdm_r_valid_i[p])      cnt[p] <= cnt[p] + CW'(1);
        else if (!inc[p] && tcdm_r_valid_i[p] && nz[p]) cnt[p] <= cnt[p] - CW'(1);
      end
    end
  end

  // Done deferral, error flag, busy and masked event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_pend <= 1'b0;
      err       <= 1'b0;
      busy_o    <= 1'b0;
      evt_o     <= '0;
    end else begin
      done_pend <= done_pend ? ~all_idle : acc_done_i;
      err       <= (err & ~err_clr) | (|perr);
      busy_o    <= acc_busy_i | done_pend | ~all_idle;
      for (int c = 0; c < N_CORES; c++) begin
        evt_o[2*c]   <= done_fire & evt_mask[c];
        evt_o[2*c+1] <= (|perr) & evt_mask[c];
      end
    end
  end

  assign cfg_gnt_o = cfg_req_i;
  assign cfg_wr    = cfg_req_i & ~cfg_wen_i;
  assign cfg_rd    = cfg_req_i & cfg_wen_i;
  assign sel       = cfg_add_i[3:2];
  assign err_clr   = cfg_wr & (sel == 2'd2) & cfg_be_i[0] & cfg_wdata_i[1];

  // Register read mux and byte-enabled mask update
  always_comb begin
    rd_data = '0;
    case (sel)
      2'd0:    rd_data[N_CORES-1:0] = evt_mask;
      2'd1:    rd_data[3:0] = {state == GATED, err, done_pend, busy_o};
      2'd2:    rd_data[0] = autogate;
      default: rd_data = '0;
    endcase
    for (int i = 0; i < N_CORES; i++)
      mask_n[i] = cfg_be_i[i/8] ? cfg_wdata_i[i] : evt_mask[i];
  end

  // Register slave state and one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_mask      <= '1;
      autogate      <= 1'b1;
      cfg_r_valid_o <= 1'b0;
      cfg_r_rdata_o <= '0;
      cfg_r_id_o    <= '0;
    end else begin
      if (cfg_wr && sel == 2'd0) evt_mask <= mask_n;
      if (cfg_wr && sel == 2'd2 && cfg_be_i[0]) autogate <= cfg_wdata_i[0];
      cfg_r_valid_o <= cfg_req_i;
      cfg_r_rdata_o <= cfg_rd ? rd_data : 32'd0;
      if (cfg_req_i) cfg_r_id_o <= cfg_id_i;
    end
  end

  // Clock-gate state register; clk_en follows the next state so a wake is seen next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACTIVE;
      idle_cnt <= '0;
      clk_en_o <= 1'b1;
    end else begin
      state    <= state_n;
      idle_cnt <= idle_cnt_n;
      clk_en_o <= (state_n != GATED) | test_mode;
    end
  end

  // Clock-gate next-state logic
  always_comb begin
    state_n    = state;
    idle_cnt_n = idle_cnt;
    case (state)
      ACTIVE: begin
        if (!busy_o && autogate && !(|acc_req_i)) begin
          state_n    = IDLE;
          idle_cnt_n = '0;
        end
      end
      IDLE: begin
        if (busy_o || (|acc_req_i) || cfg_req_i)      state_n = ACTIVE;
        else if (idle_cnt == IW'(IDLE_CYCLES - 1))    state_n = GATED;
        else                                          idle_cnt_n = idle_cnt + IW'(1);
      end
      GATED: begin
        if (acc_busy_i || acc_done_i || cfg_req_i || !autogate) state_n = ACTIVE;
      end
      default: state_n = ACTIVE;
    endcase
  end

endmodule

// File: tb/tb_hwpe_subsystem_ctrl.sv
// Bench for hwpe_subsystem_ctrl: register table, directed corner sequences
// and a randomized phase, all checked against a cycle-level behavioural model.
module tb_hwpe_subsystem_ctrl;
  localparam int NC = 8, NP = 4, IDW = 8, MAXO = 4, IDLE = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic test_mode;
  logic [NP-1:0] acc_req_i, acc_wen_i, acc_gnt_o, acc_r_valid_o;
  logic [NP*32-1:0] acc_add_i, acc_wdata_i, acc_r_rdata_o;
  logic [NP*4-1:0] acc_be_i, tcdm_be_o;
  logic [NP-1:0] tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i;
  logic [NP*32-1:0] tcdm_add_o, tcdm_wdata_o, tcdm_r_rdata_i;
  logic cfg_req_i, cfg_wen_i, cfg_gnt_o, cfg_r_valid_o;
  logic [31:0] cfg_add_i, cfg_wdata_i, cfg_r_rdata_o;
  logic [3:0] cfg_be_i;
  logic [IDW-1:0] cfg_id_i, cfg_r_id_o;
  logic acc_busy_i, acc_done_i, busy_o, clk_en_o;
  logic [NC*2-1:0] evt_o;

  always #5 clk = ~clk;

  hwpe_subsystem_ctrl #(.N_CORES(NC), .N_MASTER_PORT(NP), .ID_WIDTH(IDW),
                        .MAX_OUTSTANDING(MAXO), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .rst_n(rst_n), .test_mode(test_mode),
    .acc_req_i(acc_req_i), .acc_wen_i(acc_wen_i), .acc_add_i(acc_add_i),
    .acc_wdata_i(acc_wdata_i), .acc_be_i(acc_be_i), .acc_gnt_o(acc_gnt_o),
    .acc_r_valid_o(acc_r_valid_o), .acc_r_rdata_o(acc_r_rdata_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_wen_o(tcdm_wen_o), .tcdm_add_o(tcdm_add_o),
    .tcdm_wdata_o(tcdm_wdata_o), .tcdm_be_o(tcdm_be_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i),
    .cfg_req_i(cfg_req_i), .cfg_wen_i(cfg_wen_i), .cfg_add_i(cfg_add_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_be_i(cfg_be_i), .cfg_id_i(cfg_id_i),
    .cfg_gnt_o(cfg_gnt_o), .cfg_r_valid_o(cfg_r_valid_o), .cfg_r_rdata_o(cfg_r_rdata_o),
    .cfg_r_id_o(cfg_r_id_o), .acc_busy_i(acc_busy_i), .acc_done_i(acc_done_i),
    .evt_o(evt_o), .busy_o(busy_o), .clk_en_o(clk_en_o));

  int n_vec = 0, n_err = 0, cyc = 0;

  // behavioural model state
  int m_cnt [NP];
  bit m_done_pend, m_err, m_autogate, m_gated, m_busy, m_clk_en, m_rv;
  int m_idle_run;
  logic [NC-1:0] m_mask;
  logic [2*NC-1:0] m_evt;
  logic [31:0] m_rdata;
  logic [IDW-1:0] m_rid;

  // response scheduler: due cycle of each granted request, per port
  int rsp_q [NP][$];
  int rsp_lat = 5;
  logic [NP-1:0] inj_rv;

  // snapshots from the latest sample point
  logic [NP-1:0] s_acc_gnt, s_rv;
  logic [2*NC-1:0] s_evt;
  logic s_clk_en;
  int s_cyc;

  typedef struct {
    bit wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic [31:0] exp;
  } cfg_vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin m_cnt[p] = 0; rsp_q[p].delete(); end
    m_done_pend = 0; m_err = 0; m_autogate = 1; m_gated = 0; m_busy = 0;
    m_clk_en = 1; m_rv = 0; m_idle_run = -1; m_mask = '1; m_evt = '0;
    m_rdata = '0; m_rid = '0;
  endtask

  task automatic quiet_inputs();
    acc_req_i = '0; acc_wen_i = '0; acc_add_i = '0; acc_wdata_i = '0; acc_be_i = '0;
    tcdm_gnt_i = '1; cfg_req_i = 0; cfg_wen_i = 0; cfg_add_i = '0; cfg_wdata_i = '0;
    cfg_be_i = '0; cfg_id_i = '0; acc_busy_i = 0; acc_done_i = 0; inj_rv = '0;
  endtask

  // One clock: drive responses, compare DUT with model, advance model.
  task automatic tick();
    logic [NP-1:0] req_o, gnt_o, inc;
    logic [2*NC-1:0] n_evt;
    logic [NC-1:0] n_mask;
    logic [31:0] n_rdata;
    logic [IDW-1:0] n_rid;
    bit perr, all_zero, fire, clear, n_done, n_ag, n_err, n_gated, any_req;
    int n_cnt [NP];
    int n_idle;
    for (int p = 0; p < NP; p++) begin
      tcdm_r_valid_i[p] = inj_rv[p];
      if (rsp_q[p].size() > 0 && rsp_q[p][0] <= cyc) begin
        tcdm_r_valid_i[p] = 1'b1;
        void'(rsp_q[p].pop_front());
      end
      tcdm_r_rdata_i[p*32 +: 32] = $urandom;
    end
    #1;
    perr = 0; all_zero = 1;
    for (int p = 0; p < NP; p++) begin
      req_o[p] = acc_req_i[p] && (m_cnt[p] != MAXO);
      gnt_o[p] = tcdm_gnt_i[p] && (m_cnt[p] != MAXO);
      inc[p] = req_o[p] && tcdm_gnt_i[p];
      if (m_cnt[p] != 0) all_zero = 0;
      if (tcdm_r_valid_i[p] && m_cnt[p] == 0 && !inc[p]) perr = 1;
    end
    check("tcdm_req", tcdm_req_o, req_o);
    check("acc_gnt", acc_gnt_o, gnt_o);
    check("tcdm_add", tcdm_add_o, acc_add_i);
    check("tcdm_wdata", tcdm_wdata_o, acc_wdata_i);
    check("tcdm_wen_be", {tcdm_wen_o, tcdm_be_o}, {acc_wen_i, acc_be_i});
    check("r_rdata", acc_r_rdata_o, tcdm_r_rdata_i);
    check("r_valid", acc_r_valid_o, tcdm_r_valid_i);
    check("cfg_gnt", cfg_gnt_o, cfg_req_i);
    check("evt", evt_o, m_evt);
    check("busy", busy_o, m_busy);
    check("clk_en", clk_en_o, m_clk_en);
    check("cfg_r_valid", cfg_r_valid_o, m_rv);
    check("cfg_r_rdata", cfg_r_rdata_o, m_rdata);
    check("cfg_r_id", cfg_r_id_o, m_rid);
    s_acc_gnt = acc_gnt_o; s_rv = tcdm_r_valid_i; s_evt = evt_o; s_clk_en = clk_en_o; s_cyc = cyc;

    for (int p = 0; p < NP; p++) begin
      n_cnt[p] = m_cnt[p];
      if (inc[p] && !tcdm_r_valid_i[p]) n_cnt[p] = m_cnt[p] + 1;
      else if (!inc[p] && tcdm_r_valid_i[p] && m_cnt[p] > 0) n_cnt[p] = m_cnt[p] - 1;
      if (inc[p]) rsp_q[p].push_back(cyc + rsp_lat);
    end
    fire = m_done_pend && all_zero;
    n_done = m_done_pend ? !all_zero : acc_done_i;
    for (int c = 0; c < NC; c++) begin
      n_evt[2*c] = fire && m_mask[c];
      n_evt[2*c+1] = perr && m_mask[c];
    end
    n_rid = cfg_req_i ? cfg_id_i : m_rid;
    n_rdata = '0;
    if (cfg_req_i && cfg_wen_i) begin
      case (cfg_add_i[3:2])
        2'd0: n_rdata = 32'(m_mask);
        2'd1: n_rdata = {28'd0, m_gated, m_err, m_done_pend, m_busy};
        2'd2: n_rdata = {31'd0, m_autogate};
        default: n_rdata = '0;
      endcase
    end
    n_mask = m_mask; n_ag = m_autogate; clear = 0;
    if (cfg_req_i && !cfg_wen_i) begin
      if (cfg_add_i[3:2] == 2'd0 && cfg_be_i[0]) n_mask = cfg_wdata_i[NC-1:0];
      if (cfg_add_i[3:2] == 2'd2 && cfg_be_i[0]) begin n_ag = cfg_wdata_i[0]; clear = cfg_wdata_i[1]; end
    end
    n_err = (m_err && !clear) || perr;
    any_req = (acc_req_i != 0);
    n_gated = m_gated; n_idle = m_idle_run;
    if (m_gated) begin
      if (acc_busy_i || acc_done_i || cfg_req_i || !m_autogate) begin n_gated = 0; n_idle = -1; end
    end else if (m_idle_run < 0) begin
      if (!m_busy && m_autogate && !any_req) n_idle = 0;
    end else if (m_busy || any_req || cfg_req_i) n_idle = -1;
    else if (m_idle_run == IDLE - 1) begin n_gated = 1; n_idle = -1; end
    else n_idle = m_idle_run + 1;

    @(posedge clk);
    for (int p = 0; p < NP; p++) m_cnt[p] = n_cnt[p];
    m_busy = acc_busy_i || m_done_pend || !all_zero;
    m_done_pend = n_done; m_evt = n_evt; m_err = n_err; m_mask = n_mask; m_autogate = n_ag;
    m_rv = cfg_req_i; m_rdata = n_rdata; m_rid = n_rid;
    m_gated = n_gated; m_idle_run = n_idle; m_clk_en = !n_gated || test_mode;
    @(negedge clk);
    cyc++;
    inj_rv = '0;
  endtask

  task automatic cfg_xact(input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [IDW-1:0] id,
                          output logic [31:0] rdata, output logic rv, output logic [IDW-1:0] rid);
    cfg_req_i = 1; cfg_wen_i = wen; cfg_add_i = addr; cfg_wdata_i = wdata; cfg_be_i = be; cfg_id_i = id;
    tick();
    cfg_req_i = 0;
    rdata = cfg_r_rdata_o; rv = cfg_r_valid_o; rid = cfg_r_id_o;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    bit busy_q;
    busy_q = 1;
    while (busy_q && k < bound) begin
      tick(); k++;
      busy_q = 0;
      for (int p = 0; p < NP; p++) if (rsp_q[p].size() != 0 || m_cnt[p] != 0) busy_q = 1;
    end
    check("drain_timeout", busy_q, 1'b0);
  endtask

  cfg_vec_t tbl [$];
  logic [31:0] rd;
  logic rv;
  logic [IDW-1:0] rid;
  int grants, first_rv, gnt_before, last_rv, t0, found, zeros;

  initial begin
    quiet_inputs();
    test_mode = 0;
    tcdm_gnt_i = '0;
    tcdm_r_valid_i = '0;
    tcdm_r_rdata_i = '0;
    model_reset();
    #12;
    check("rst_busy", busy_o, 1'b0);
    check("rst_evt", evt_o, '0);
    check("rst_clk_en", clk_en_o, 1'b1);
    check("rst_cfg", {cfg_r_valid_o, cfg_r_rdata_o, cfg_r_id_o}, '0);
    check("rst_gnt", {acc_gnt_o, tcdm_req_o}, '0);
    @(negedge clk);
    rst_n = 1;
    tcdm_gnt_i = '1;

    // register table
    tbl.push_back('{1, 32'h0, 32'h0, 4'hF, 32'hFF});
    tbl.push_back('{0, 32'h0, 32'hA5, 4'h1, 32'h0});
    tbl.push_back('{1, 32'h0, 32'h0, 4'hF, 32'hA5});
    tbl.push_back('{0, 32'h0, 32'h12345600, 4'hE, 32'h0});
    tbl.push_back('{1, 32'h0, 32'h0, 4'hF, 32'hA5});
    tbl.push_back('{1, 32'hC, 32'h0, 4'hF, 32'h0});
    tbl.push_back('{1, 32'h8, 32'h0, 4'hF, 32'h1});
    tbl.push_back('{0, 32'h8, 32'h0, 4'h1, 32'h0});
    tbl.push_back('{1, 32'h8, 32'h0, 4'hF, 32'h0});
    tbl.push_back('{0, 32'h8, 32'h1, 4'h0, 32'h0});
    tbl.push_back('{1, 32'h8, 32'h0, 4'hF, 32'h0});
    tbl.push_back('{0, 32'h8, 32'h1, 4'h1, 32'h0});
    tbl.push_back('{1, 32'h4, 32'h0, 4'hF, 32'h0});
    tbl.push_back('{0, 32'h0, 32'hFF, 4'h1, 32'h0});
    tbl.push_back('{1, 32'h0, 32'h0, 4'hF, 32'hFF});
    for (int i = 0; i < tbl.size(); i++) begin
      cfg_xact(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].be, IDW'(i + 8'h30), rd, rv, rid);
      check("tbl_rdata", rd, tbl[i].exp);
      check("tbl_rv_id", {rv, rid}, {1'b1, IDW'(i + 8'h30)});
      tick();
    end

    // six back-to-back reads on port 0, 5-cycle response latency
    rsp_lat = 5; grants = 0; first_rv = -1; gnt_before = 0;
    acc_req_i[0] = 1; acc_wen_i[0] = 1; acc_add_i[31:0] = 32'h1000_0040;
    for (int k = 0; k < 40 && grants < 6; k++) begin
      tick();
      if (s_rv[0] && first_rv < 0) first_rv = s_cyc;
      if (s_acc_gnt[0]) grants++;
      if (first_rv < 0 || first_rv == s_cyc) gnt_before += s_acc_gnt[0];
    end
    acc_req_i = '0;
    check("six_grants", grants, 6);
    check("grants_until_first_rv", gnt_before, 4);
    drain(40);

    // done deferred behind two writes on port 2
    rsp_lat = 6;
    acc_req_i[2] = 1; acc_wen_i[2] = 0; acc_wdata_i[95:64] = 32'hCAFE_F00D; acc_be_i[11:8] = 4'hF;
    tick(); tick();
    acc_req_i = '0; acc_done_i = 1;
    tick();
    acc_done_i = 0;
    last_rv = -1; found = -1;
    for (int k = 0; k < 30 && found < 0; k++) begin
      tick();
      if (s_rv[2]) last_rv = s_cyc;
      if (s_evt != 0) begin
        found = s_cyc;
        check("defer_evt_val", s_evt, 16'h5555);
        check("defer_no_rv_pending", rsp_q[2].size(), 0);
      end
    end
    check("defer_evt_cycle", found, last_rv + 2);
    tick();
    check("defer_evt_one_cycle", s_evt, 16'h0);

    // masked done with no traffic
    cfg_xact(0, 32'h0, 32'h05, 4'h1, 8'h11, rd, rv, rid);
    acc_done_i = 1; t0 = cyc;
    tick();
    acc_done_i = 0; found = -1;
    for (int k = 0; k < 10 && found < 0; k++) begin
      tick();
      if (s_evt != 0) begin found = s_cyc; check("masked_done_val", s_evt, 16'h0011); end
    end
    check("masked_done_cycle", found, t0 + 2);
    cfg_xact(1, 32'h0, 32'h0, 4'hF, 8'h5A, rd, rv, rid);
    check("mask_read", {rv, rid, rd}, {1'b1, 8'h5A, 32'h5});

    // stray response on port 1
    inj_rv[1] = 1;
    tick();
    tick();
    check("err_evt", s_evt, 16'h0022);
    tick();
    check("err_evt_one_cycle", s_evt, 16'h0);
    cfg_xact(1, 32'h4, 32'h0, 4'hF, 8'h21, rd, rv, rid);
    check("status_err", rd[2], 1'b1);
    cfg_xact(0, 32'h8, 32'h3, 4'hF, 8'h22, rd, rv, rid);
    cfg_xact(1, 32'h4, 32'h0, 4'hF, 8'h23, rd, rv, rid);
    check("status_err_cleared", rd[2], 1'b0);
    cfg_xact(1, 32'h8, 32'h0, 4'hF, 8'h24, rd, rv, rid);
    check("ctrl_autogate", rd, 32'h1);

    // idle gating and wake by cfg read
    found = -1;
    for (int k = 0; k < 40 && found < 0; k++) begin
      tick();
      if (!s_clk_en) found = s_cyc;
    end
    check("gate_reached", found >= 0, 1'b1);
    cfg_xact(1, 32'h4, 32'h0, 4'hF, 8'h77, rd, rv, rid);
    check("gated_status", {rv, rid, rd}, {1'b1, 8'h77, 32'h8});
    check("wake_clk_en", clk_en_o, 1'b1);
    test_mode = 1; zeros = 0;
    for (int k = 0; k < 40; k++) begin tick(); if (!s_clk_en) zeros++; end
    check("test_mode_no_gate", zeros, 0);
    test_mode = 0;
    tick();

    // reset with three in flight and done pending
    rsp_lat = 30;
    acc_req_i[3] = 1; acc_wen_i[3] = 1;
    tick(); tick(); tick();
    acc_req_i = '0; acc_done_i = 1;
    tick();
    acc_done_i = 0;
    tick();
    #2 rst_n = 0;
    #1;
    acc_req_i[3] = 1; tcdm_gnt_i = '1; tcdm_r_valid_i = '0;
    #1;
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_evt", evt_o, '0);
    check("mid_rst_clk_en", clk_en_o, 1'b1);
    check("mid_rst_cnt0", {acc_gnt_o[3], tcdm_req_o[3]}, 2'b11);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    quiet_inputs();
    model_reset();
    for (int k = 0; k < 6; k++) tick();
    cfg_xact(1, 32'h0, 32'h0, 4'hF, 8'h99, rd, rv, rid);
    check("post_rst_mask", rd, 32'hFF);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ((i % 300) >= 260) quiet_inputs();
      else begin
        rsp_lat = $urandom_range(1, 8);
        acc_req_i = NP'($urandom); acc_wen_i = NP'($urandom);
        acc_add_i = {$urandom, $urandom, $urandom, $urandom};
        acc_wdata_i = {$urandom, $urandom, $urandom, $urandom};
        acc_be_i = 16'($urandom);
        for (int p = 0; p < NP; p++) tcdm_gnt_i[p] = ($urandom_range(0, 9) < 7);
        acc_busy_i = ($urandom_range(0, 9) == 0);
        acc_done_i = ($urandom_range(0, 19) == 0);
        cfg_req_i = ($urandom_range(0, 4) == 0);
        cfg_wen_i = $urandom_range(0, 1);
        cfg_add_i = $urandom; cfg_wdata_i = $urandom; cfg_be_i = 4'($urandom); cfg_id_i = 8'($urandom);
        for (int p = 0; p < NP; p++)
          if (rsp_q[p].size() == 0 && $urandom_range(0, 49) == 0) inj_rv[p] = 1;
      end
      if ($urandom_range(0, 99) == 0) test_mode = ~test_mode;
      tick();
    end
    quiet_inputs();
    test_mode = 0;
    drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
